// File: rtl/tile_mem_pkg.sv
// tile_mem_pkg: shared constants and enums for the board tile store arbiter.
// Board layout: 24 edge-path cells (0..23) followed by 12 center cells (24..35).
package tile_mem_pkg;

   localparam int unsigned DEPTH      = 36;
   localparam int unsigned EDGE_CNT   = 24;
   localparam int unsigned CENTER_CNT = 12;
   localparam int unsigned DW         = 4;
   localparam int unsigned AW         = 6;

   typedef enum logic [1:0] {
      S_IDLE,
      S_INIT,
      S_RUN
   } state_e;

   typedef enum logic {
      REQ_GAME,
      REQ_DISP
   } req_id_e;

endpackage

// File: rtl/tile_mem_arbiter_rr_arb2.sv
// rr_arb2: two-requester arbiter (game / display) for the tile store.
// Default build: round robin, ties go to whoever was not granted last.
// Define TILE_ARB_GAME_PRIORITY_EN for fixed priority (game always wins ties).
module rr_arb2
   import tile_mem_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   input  logic req_game_i,
   input  logic req_disp_i,
   output logic gnt_game_o,
   output logic gnt_disp_o
);

`ifdef TILE_ARB_GAME_PRIORITY_EN

   // Fixed priority: display only wins when the game is not requesting
   always_comb begin
      gnt_game_o = en_i & req_game_i;
      gnt_disp_o = en_i & req_disp_i & ~req_game_i;
   end

`else

   req_id_e last_q;

   // Grant decision: a lone requester wins; a tie goes to the one not granted last
   always_comb begin
      gnt_game_o = en_i & req_game_i & (~req_disp_i | (last_q == REQ_DISP));
      gnt_disp_o = en_i & req_disp_i & (~req_game_i | (last_q == REQ_GAME));
   end

   // Remember the most recent winner; resets to display so game wins the first tie
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= REQ_DISP;
      end else if (gnt_game_o) begin
         last_q <= REQ_GAME;
      end else if (gnt_disp_o) begin
         last_q <= REQ_DISP;
      end
   end

`endif

endmodule

// File: rtl/tile_mem_arbiter.sv
// tile_mem_arbiter: owns the 36 x 4-bit board tile store. Loads a 144-bit
// board one cell per cycle, then shares single-cell access between the game
// logic (read/write) and the display scanner (read-only), one access per cycle.
// Arbitration policy selected by TILE_ARB_GAME_PRIORITY_EN (see rr_arb2).
module tile_mem_arbiter #(
   parameter int unsigned DEPTH    = tile_mem_pkg::DEPTH,
   parameter int unsigned EDGE_CNT = tile_mem_pkg::EDGE_CNT,
   parameter int unsigned DW       = tile_mem_pkg::DW,
   parameter int unsigned AW       = tile_mem_pkg::AW
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                init_start,
   input  logic [DEPTH*DW-1:0] board_in,
   output logic                init_busy,
   output logic                init_done,
   input  logic                g_req,
   input  logic                g_we,
   input  logic [AW-1:0]       g_addr,
   input  logic [DW-1:0]       g_wdata,
   output logic                g_gnt,
   output logic                g_rvalid,
   output logic [DW-1:0]       g_rdata,
   input  logic                d_req,
   input  logic [AW-1:0]       d_addr,
   output logic                d_gnt,
   output logic                d_rvalid,
   output logic [DW-1:0]       d_rdata,
   output logic                addr_err
);

   import tile_mem_pkg::*;

   if (EDGE_CNT > DEPTH) begin : g_cfg_err
      $error("tile_mem_arbiter: EDGE_CNT exceeds DEPTH");
   end

   state_e              state_q;
   logic [AW-1:0]       load_cnt_q;
   logic [DEPTH*DW-1:0] shadow_q;
   logic                init_busy_q;
   logic                init_done_q;
   logic [DW-1:0]       mem_q [DEPTH];

   logic                g_rvalid_q;
   logic [DW-1:0]       g_rdata_q;
   logic                d_rvalid_q;
   logic [DW-1:0]       d_rdata_q;
   logic                addr_err_q;

   logic                run;
   logic                gnt_g;
   logic                gnt_d;
   logic [AW-1:0]       acc_addr;
   logic                acc_in_range;
   logic [DW-1:0]       acc_rdata;

   assign run = (state_q == S_RUN);

   rr_arb2 u_arb (
      .clk        (clk),
      .rst_n      (rst_n),
      .en_i       (run),
      .req_game_i (g_req),
      .req_disp_i (d_req),
      .gnt_game_o (gnt_g),
      .gnt_disp_o (gnt_d)
   );

   // Single shared access port: select the granted address and fetch its cell
   always_comb begin
      acc_addr     = gnt_g ? g_addr : d_addr;
      acc_in_range = (acc_addr < AW'(DEPTH));
      acc_rdata    = '0;
      if (acc_in_range) begin
         acc_rdata = mem_q[acc_addr];
      end
   end

   // Control FSM: board load sequencing with registered busy/done flags.
   // The shadow register shifts left each load cycle so the next cell is always on top.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         load_cnt_q  <= '0;
         shadow_q    <= '0;
         init_busy_q <= 1'b0;
         init_done_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_RUN: begin
               if (init_start) begin
                  state_q     <= S_INIT;
                  shadow_q    <= board_in;
                  load_cnt_q  <= '0;
                  init_busy_q <= 1'b1;
                  init_done_q <= 1'b0;
               end
            end
            S_INIT: begin
               shadow_q   <= shadow_q << DW;
               load_cnt_q <= load_cnt_q + AW'(1);
               if (load_cnt_q == AW'(DEPTH - 1)) begin
                  state_q     <= S_RUN;
                  init_busy_q <= 1'b0;
                  init_done_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               init_busy_q <= 1'b0;
               init_done_q <= 1'b0;
            end
         endcase
      end
   end

   // Tile store: load writes during S_INIT, in-range granted game writes during S_RUN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (state_q == S_INIT) begin
         mem_q[load_cnt_q] <= shadow_q[DEPTH*DW-1 -: DW];
      end else if (gnt_g && g_we && acc_in_range) begin
         mem_q[g_addr] <= g_wdata;
      end
   end

   // Read pipeline: one-cycle registered read data, held while rvalid is low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         g_rvalid_q <= 1'b0;
         g_rdata_q  <= '0;
         d_rvalid_q <= 1'b0;
         d_rdata_q  <= '0;
         addr_err_q <= 1'b0;
      end else begin
         g_rvalid_q <= gnt_g & ~g_we;
         d_rvalid_q <= gnt_d;
         addr_err_q <= (gnt_g | gnt_d) & ~acc_in_range;
         if (gnt_g && !g_we) begin
            g_rdata_q <= acc_rdata;
         end
         if (gnt_d) begin
            d_rdata_q <= acc_rdata;
         end
      end
   end

   assign init_busy = init_busy_q;
   assign init_done = init_done_q;
   assign g_gnt     = gnt_g;
   assign d_gnt     = gnt_d;
   assign g_rvalid  = g_rvalid_q;
   assign g_rdata   = g_rdata_q;
   assign d_rvalid  = d_rvalid_q;
   assign d_rdata   = d_rdata_q;
   assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_tile_mem_arbiter.sv
// tb_tile_mem_arbiter: directed stimulus with a per-cycle behavioural model
// of the tile store plus hand-computed literal expectations.
module tb_tile_mem_arbiter;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         init_start = 1'b0;
   logic [143:0] board_in = '0;
   logic         init_busy, init_done;
   logic         g_req = 1'b0, g_we = 1'b0;
   logic [5:0]   g_addr = '0;
   logic [3:0]   g_wdata = '0;
   logic         g_gnt, g_rvalid;
   logic [3:0]   g_rdata;
   logic         d_req = 1'b0;
   logic [5:0]   d_addr = '0;
   logic         d_gnt, d_rvalid;
   logic [3:0]   d_rdata;
   logic         addr_err;

   always #5 clk = ~clk;

   tile_mem_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .init_start (init_start),
      .board_in   (board_in),
      .init_busy  (init_busy),
      .init_done  (init_done),
      .g_req      (g_req),
      .g_we       (g_we),
      .g_addr     (g_addr),
      .g_wdata    (g_wdata),
      .g_gnt      (g_gnt),
      .g_rvalid   (g_rvalid),
      .g_rdata    (g_rdata),
      .d_req      (d_req),
      .d_addr     (d_addr),
      .d_gnt      (d_gnt),
      .d_rvalid   (d_rvalid),
      .d_rdata    (d_rdata),
      .addr_err   (addr_err)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   int           m_mem [36];
   logic [143:0] m_shadow;
   bit           m_loading, m_ready, m_last_game;
   int           m_idx;
   bit           e_g_rvalid, e_d_rvalid, e_err, e_busy, e_done;
   int           e_g_rdata, e_d_rdata;

   function automatic bit exp_ggnt();
      return m_ready && g_req && (!d_req || !m_last_game);
   endfunction

   function automatic bit exp_dgnt();
      return m_ready && d_req && (!g_req || m_last_game);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         foreach (m_mem[i]) m_mem[i] = 0;
         m_shadow = '0; m_loading = 0; m_ready = 0; m_last_game = 0; m_idx = 0;
         e_g_rvalid = 0; e_d_rvalid = 0; e_err = 0; e_busy = 0; e_done = 0;
         e_g_rdata = 0; e_d_rdata = 0;
      end else begin
         bit gg, dg;
         gg = exp_ggnt();
         dg = exp_dgnt();
         e_g_rvalid = gg && !g_we;
         if (e_g_rvalid) e_g_rdata = (g_addr < 36) ? m_mem[g_addr] : 0;
         e_d_rvalid = dg;
         if (dg) e_d_rdata = (d_addr < 36) ? m_mem[d_addr] : 0;
         e_err = (gg && g_addr >= 36) || (dg && d_addr >= 36);
         if (gg && g_we && g_addr < 36) m_mem[g_addr] = int'(g_wdata);
         if (gg) m_last_game = 1;
         if (dg) m_last_game = 0;
         if (m_loading) begin
            m_mem[m_idx] = int'(m_shadow[143-4*m_idx -: 4]);
            m_idx++;
            if (m_idx == 36) begin
               m_loading = 0; m_ready = 1; e_done = 1;
            end
         end else if (init_start) begin
            m_shadow = board_in; m_loading = 1; m_idx = 0; m_ready = 0; e_done = 0;
         end
         e_busy = m_loading;
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      chk("g_gnt",     g_gnt,     exp_ggnt());
      chk("d_gnt",     d_gnt,     exp_dgnt());
      chk("g_rvalid",  g_rvalid,  e_g_rvalid);
      chk("g_rdata",   g_rdata,   e_g_rdata);
      chk("d_rvalid",  d_rvalid,  e_d_rvalid);
      chk("d_rdata",   d_rdata,   e_d_rdata);
      chk("addr_err",  addr_err,  e_err);
      chk("init_busy", init_busy, e_busy);
      chk("init_done", init_done, e_done);
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue a game access and hold it until granted; returns in the cycle after the grant
   task automatic game_req(input bit we, input int a, input int wd);
      bit got;
      got = 0;
      g_req = 1; g_we = we; g_addr = 6'(a); g_wdata = 4'(wd);
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         if (g_gnt) begin got = 1; break; end
         tick();
      end
      if (!got) chk("g_gnt_timeout", 0, 1);
      tick();
      g_req = 0; g_we = 0;
   endtask

   task automatic disp_read(input int a, output int data);
      bit got;
      got = 0;
      d_req = 1; d_addr = 6'(a);
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         if (d_gnt) begin got = 1; break; end
         tick();
      end
      if (!got) chk("d_gnt_timeout", 0, 1);
      tick();
      d_req = 0;
      @(negedge clk);
      data = int'(d_rdata);
      tick();
   endtask

   task automatic wait_done();
      bit got;
      got = 0;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         if (init_done) begin got = 1; break; end
         tick();
      end
      if (!got) chk("init_done_timeout", 0, 1);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      logic [143:0] board_a, board_f;
      int v, gnt_cyc;
      logic [3:0] gseq, dseq;

      for (int i = 0; i < 36; i++) board_a[143-4*i -: 4] = 4'(i % 16);
      board_f = '1;

      #1 rst_n = 0;
      repeat (2) tick();
      @(negedge clk);
      chk("rst_busy", init_busy, 0);
      chk("rst_done", init_done, 0);
      chk("rst_rvalid", g_rvalid | d_rvalid, 0);
      chk("rst_rdata", int'(g_rdata) + int'(d_rdata), 0);
      tick();
      rst_n = 1;
      tick();

      // Blocking in S_IDLE
      d_req = 1; d_addr = 0;
      repeat (3) begin
         @(negedge clk);
         chk("idle_no_dgnt", d_gnt, 0);
         tick();
      end

      // Load with d_req held; second init_start in cycle 10 must be ignored
      init_start = 1; board_in = board_a;
      tick();
      init_start = 0; board_in = '0;
      gnt_cyc = 0;
      for (int c = 1; c < 100; c++) begin
         if (c == 10) begin init_start = 1; board_in = board_f; end
         else begin init_start = 0; board_in = '0; end
         @(negedge clk);
         if (c == 1)  chk("busy_first", init_busy, 1);
         if (c == 36) chk("busy_last", init_busy, 1);
         if (d_gnt) begin gnt_cyc = c; break; end
         tick();
      end
      chk("dgnt_cycle", gnt_cyc, 37);
      chk("done_at_gnt", init_done, 1);
      chk("busy_off_37", init_busy, 0);
      tick();
      d_req = 0;
      @(negedge clk);
      chk("rd_addr0", d_rdata, 0);
      tick();
      disp_read(23, v); chk("rd_addr23", v, 7);
      disp_read(24, v); chk("rd_addr24", v, 8);
      disp_read(35, v); chk("rd_addr35", v, 3);

      // Contention: last winner is display, so game wins first
      g_req = 1; g_we = 0; g_addr = 5; d_req = 1; d_addr = 9;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         gseq[3-i] = g_gnt;
         dseq[3-i] = d_gnt;
         if (i == 1) chk("cont_g_rdata", g_rdata, 5);
         if (i == 2) chk("cont_d_rdata", d_rdata, 9);
         tick();
      end
      g_req = 0; d_req = 0;
      chk("cont_gseq", gseq, 4'b1010);
      chk("cont_dseq", dseq, 4'b0101);
      @(negedge clk);
      chk("cont_last_d", d_rvalid, 1);
      tick();

      // Write then read next cycle
      game_req(1, 30, 'hA);
      disp_read(30, v); chk("wr_then_rd", v, 10);

      // Out-of-range read and write
      game_req(0, 40, 0);
      @(negedge clk);
      chk("oor_rdata", g_rdata, 0);
      chk("oor_rvalid", g_rvalid, 1);
      chk("oor_err", addr_err, 1);
      tick();
      @(negedge clk);
      chk("oor_err_once", addr_err, 0);
      tick();
      game_req(1, 36, 7);
      @(negedge clk);
      chk("oor_wr_err", addr_err, 1);
      tick();
      for (int i = 0; i < 36; i++) begin
         disp_read(i, v);
         chk("cells_after_oor", v, (i == 30) ? 10 : (i % 16));
      end

      // Reset mid-load
      init_start = 1; board_in = board_a;
      tick();
      init_start = 0; board_in = '0;
      repeat (9) tick();
      rst_n = 0;
      @(negedge clk);
      chk("midrst_busy", init_busy, 0);
      chk("midrst_done", init_done, 0);
      chk("midrst_out", int'(g_rvalid) + int'(d_rvalid) + int'(addr_err) + int'(g_rdata) + int'(d_rdata), 0);
      tick();
      rst_n = 1;
      tick();
      init_start = 1; board_in = '0;
      tick();
      init_start = 0;
      wait_done();
      for (int i = 0; i < 36; i++) begin
         disp_read(i, v);
         chk("zero_board", v, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/tile_mem_arbiter.md
# tile_mem_arbiter

Owns the 36-entry × 4-bit board tile store: 24 edge-path cells followed by 12 center cells. Sequences a bulk board load from a 144-bit vector, one cell per cycle, then shares single-cell access between the game-logic requester (read/write) and the display scanner (read-only). Sits between the board shuffler/game FSM and the VGA/LED tile renderer. Replaces direct bulk-write access to the tile memory.

## Interface
Parameters:
- DEPTH, 36, total cells
- EDGE_CNT, 24, edge cells at addresses 0..23; center cells at 24..35
- DW, 4, tile code width
- AW, 6, address width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- init_start  in  1  pulse; samples board_in and starts the load
- board_in  in  144  cell i = board_in[143-4i -: 4]
- init_busy  out  1  load in progress
- init_done  out  1  level; board valid
- g_req  in  1  game request
- g_we  in  1  1 = write, 0 = read
- g_addr  in  AW  game address
- g_wdata  in  DW  game write data
- g_gnt  out  1  game access accepted this cycle
- g_rvalid  out  1  game read data valid
- g_rdata  out  DW  game read data
- d_req  in  1  display read request
- d_addr  in  AW  display address
- d_gnt  out  1  display access accepted this cycle
- d_rvalid  out  1  display read data valid
- d_rdata  out  DW  display read data
- addr_err  out  1  one-cycle pulse on a granted access with addr ≥ DEPTH

## Operation
- FSM states:
  - S_IDLE: no board loaded; no grants.
  - S_INIT: load cells 0..35.
  - S_RUN: arbitrate requests.
- Transitions:
  - S_IDLE → S_INIT on init_start.
  - S_RUN → S_INIT on init_start; in-flight read data still returns.
  - S_INIT → S_RUN after cell 35 is written.
  - init_start during S_INIT is ignored.
- Load:
  - board_in is captured into a 144-bit shadow register on init_start.
  - A 6-bit counter writes cell k on the k-th busy cycle.
  - init_done clears on init_start and sets on entry to S_RUN.
- Arbitration (S_RUN only):
  - At most one access per cycle.
  - gnt is combinational from req, state and the last-winner flag.
  - If only one requester is active, it wins.
  - If both are active, the requester not granted last wins (round robin).
  - The last-winner flag resets to "display", so game wins the first tie.
- Requesters hold req and address until gnt. Requests in S_IDLE or S_INIT stay pending and are not granted.
- Granted write: the cell updates at the clock edge; no rvalid is returned.
- Granted read: rvalid and rdata are registered one cycle later. rdata holds its last value while rvalid = 0.
- Out-of-range address (≥ 36) is still granted:
  - a write is dropped;
  - a read returns 4'h0 with rvalid;
  - addr_err pulses in the cycle after the grant.

## Timing
- Reset values:
  - state S_IDLE, all memory cells 0;
  - gnt, rvalid, rdata, init_busy, init_done, addr_err all 0;
  - last-winner flag = display.
- Load latency:
  - init_start in cycle 0;
  - init_busy high cycles 1..36; cell k written at the end of cycle k+1;
  - init_done high from cycle 37; first grant possible in cycle 37.
- Read latency is 1 cycle: gnt in cycle n, rvalid/rdata in cycle n+1.
- A game write at the end of cycle n is visible to a display read granted in cycle n+1 (data in n+2).
- Back-to-back grants to the same requester are allowed when the other requester is idle.
- Reset mid-load aborts the load: state returns to S_IDLE, memory cells return to 0, pending reads are discarded.

## Configuration
- TILE_ARB_GAME_PRIORITY_EN defined: fixed priority; game always wins ties; the last-winner flag is removed.
- Undefined: round robin as described above.

## Structure
- tile_mem_pkg holds:
  - DEPTH, EDGE_CNT, CENTER_CNT (12), DW, AW;
  - the state enum (S_IDLE, S_INIT, S_RUN);
  - the requester-id enum (REQ_GAME, REQ_DISP).
- Sub-module rr_arb2: two-requester round-robin/priority arbiter, with the macro applied inside it. The top level holds the FSM, load counter, memory array and read pipeline.

## Test plan
- Load: init_start with board_in = {36 nibbles 0..35 mod 16} → init_busy for 36 cycles, init_done in cycle 37; display reads of addresses 0, 23, 24 and 35 return 0, 7, 8 and 3.
- Contention: in S_RUN, hold g_req (read, addr 5) and d_req (addr 9) for 4 cycles → grants G, D, G, D; each rdata arrives 1 cycle after its gnt.
- Write-then-read: game writes 4'hA to addr 30, display reads addr 30 in the next cycle → d_rdata = 4'hA.
- Range check: game read of addr 40 → granted, g_rdata = 0 with g_rvalid, addr_err pulses once; a write to addr 36 leaves all cells unchanged.
- Blocking: d_req asserted in S_IDLE and during a load → no d_gnt until the cycle init_done rises; a second init_start mid-load is ignored.
- Reset mid-load: rst_n low in cycle 10 of a load → all outputs 0, state S_IDLE, all cells read 0 after a new load of an all-zero board.
